alu_resp_checker: RTL and testbench

Synthesizable self-checking response monitor for the 8-bit ALU. It sits on the ALU output side, opposite the stimulus driver. Each cycle it samples an operand/opcode/result tuple and recomputes the expected result with an internal reference model. It counts transactions and mismatches, and captures the first failing tuple for readback by a bench or on-chip debug logic.

---
 rtl/alu_resp_checker.sv | 146 ++++++++++++++
 tb/tb_alu_resp_checker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_resp_checker.sv
// Self-checking response monitor for the 8-bit ALU: recomputes each sampled result,
// counts transactions and mismatches, and captures the first failing tuple.
module alu_resp_checker #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CNT_W       = 16,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] dut_out,
  output logic             mismatch,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_a,
  output logic [WIDTH-1:0] first_b,
  output logic [2:0]       first_op,
  output logic [WIDTH-1:0] first_got,
  output logic [WIDTH-1:0] first_exp,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t st_q, st_d;

  logic             v1;
  logic [WIDTH-1:0] a1, b1, got1, exp1;
  logic [2:0]       op1;
  logic [WIDTH-1:0] exp_d;
  logic             cmp_en, bad, load;

  // Reference model; sums and shifts truncate naturally to WIDTH.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    exp_d = '0;
    unique case (op)
      3'd0: exp_d = a + b;
      3'd1: exp_d = a - b;
      3'd2: exp_d = a & b;
      3'd3: exp_d = a | b;
      3'd4: exp_d = a ^ b;
      3'd5: exp_d = ~a;
      3'd6: exp_d = a << 1;
      3'd7: exp_d = a >> 1;
      default: exp_d = '0;
    endcase
  end

  // In stop mode a FAIL state discards whatever is in S1 and blocks new loads,
  // including the tuple arriving on the same edge the failure is detected.
  assign cmp_en = v1 && !(STOP_ON_ERR && (st_q == FAIL));
  assign bad    = cmp_en && (got1 != exp1);
  assign load   = in_valid && !(STOP_ON_ERR && ((st_q == FAIL) || bad));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      op1  <= '0;
      got1 <= '0;
      exp1 <= '0;
    end else if (clear) begin
      v1   <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      op1  <= '0;
      got1 <= '0;
      exp1 <= '0;
    end else begin
      v1 <= load;
      if (in_valid) begin
        a1   <= a;
        b1   <= b;
        op1  <= op;
        got1 <= dut_out;
        exp1 <= exp_d;
      end
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (bad) st_d = FAIL; else if (cmp_en) st_d = RUN;
      RUN:     if (bad) st_d = FAIL;
      FAIL:    st_d = FAIL;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q            <= IDLE;
      mismatch        <= 1'b0;
      txn_cnt         <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_a         <= '0;
      first_b         <= '0;
      first_op        <= '0;
      first_got       <= '0;
      first_exp       <= '0;
    end else if (clear) begin
      st_q            <= IDLE;
      mismatch        <= 1'b0;
      txn_cnt         <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_a         <= '0;
      first_b         <= '0;
      first_op        <= '0;
      first_got       <= '0;
      first_exp       <= '0;
    end else begin
      st_q     <= st_d;
      mismatch <= bad;
      if (cmp_en && (txn_cnt != CNT_MAX)) txn_cnt <= txn_cnt + CNT_W'(1);
      if (bad && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + CNT_W'(1);
      if (bad && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_a         <= a1;
        first_b         <= b1;
        first_op        <= op1;
        first_got       <= got1;
        first_exp       <= exp1;
      end
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_alu_resp_checker.sv
// Scoreboard bench: three checker configurations share one stimulus stream and are
// compared every cycle against a transaction-level model of the expected outputs.
module tb_alu_resp_checker;

  typedef struct packed {
    logic        mm;
    logic [31:0] txn;
    logic [31:0] err;
    logic [1:0]  st;
    logic        fev;
    logic [7:0]  fa;
    logic [7:0]  fb;
    logic [2:0]  fop;
    logic [7:0]  fgot;
    logic [7:0]  fexp;
  } snap_t;

  typedef struct packed {
    logic [31:0] due;
    snap_t [2:0] s;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0, b = '0, dut_out = '0;
  logic [2:0] op = '0;

  logic        mm0, mm1, mm2, fev0, fev1, fev2;
  logic [15:0] txn0, txn1, err0, err1;
  logic [3:0]  txn2, err2;
  logic [7:0]  fa0, fa1, fa2, fb0, fb1, fb2, fg0, fg1, fg2, fe0, fe1, fe2;
  logic [2:0]  fo0, fo1, fo2;
  logic [1:0]  st0, st1, st2;

  int     cyc = 0;
  int     n_cmp = 0;
  int     n_err = 0;
  int     u2_pulses = 0;
  entry_t sb[$];
  snap_t [2:0] mdl = '0;
  snap_t [2:0] cur = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_resp_checker #(.WIDTH(8), .CNT_W(16), .STOP_ON_ERR(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .a(a), .b(b), .op(op),
    .dut_out(dut_out), .mismatch(mm0), .txn_cnt(txn0), .err_cnt(err0), .first_err_valid(fev0),
    .first_a(fa0), .first_b(fb0), .first_op(fo0), .first_got(fg0), .first_exp(fe0), .state(st0));

  alu_resp_checker #(.WIDTH(8), .CNT_W(16), .STOP_ON_ERR(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .a(a), .b(b), .op(op),
    .dut_out(dut_out), .mismatch(mm1), .txn_cnt(txn1), .err_cnt(err1), .first_err_valid(fev1),
    .first_a(fa1), .first_b(fb1), .first_op(fo1), .first_got(fg1), .first_exp(fe1), .state(st1));

  alu_resp_checker #(.WIDTH(8), .CNT_W(4), .STOP_ON_ERR(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .a(a), .b(b), .op(op),
    .dut_out(dut_out), .mismatch(mm2), .txn_cnt(txn2), .err_cnt(err2), .first_err_valid(fev2),
    .first_a(fa2), .first_b(fb2), .first_op(fo2), .first_got(fg2), .first_exp(fe2), .state(st2));

  // ALU behaviour stated with plain integer arithmetic modulo 256.
  function automatic logic [7:0] ref_alu(int x, int y, int o);
    int r;
    case (o)
      0: r = (x + y) % 256;
      1: r = (x - y + 256) % 256;
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = 255 - x;
      6: r = (x * 2) % 256;
      default: r = x / 2;
    endcase
    return r[7:0];
  endfunction

  task automatic check(string name, int u, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s u%0d cyc=%0d got=%0h expected=%0h", name, u, cyc, got, exp);
    end
  endtask

  // Expected effect of one accepted tuple on each configuration, due two cycles later.
  task automatic model_issue(logic [7:0] ta, logic [7:0] tb, logic [2:0] top, logic [7:0] tgot);
    entry_t     en;
    logic [7:0] e;
    bit         is_bad;
    e      = ref_alu(int'(ta), int'(tb), int'(top));
    is_bad = (tgot != e);
    en.due = cyc + 2;
    for (int i = 0; i < 3; i++) begin
      snap_t s;
      int    mx;
      mx   = (i == 2) ? 15 : 65535;
      s    = mdl[i];
      s.mm = 1'b0;
      if (!((i == 1) && (s.st == 2'd2))) begin
        if (s.txn < mx) s.txn = s.txn + 1;
        if (is_bad) begin
          s.mm = 1'b1;
          if (s.err < mx) s.err = s.err + 1;
          if (!s.fev) begin
            s.fev = 1'b1; s.fa = ta; s.fb = tb; s.fop = top; s.fgot = tgot; s.fexp = e;
          end
          s.st = 2'd2;
        end else if (s.st == 2'd0) begin
          s.st = 2'd1;
        end
      end
      mdl[i]  = s;
      en.s[i] = s;
    end
    sb.push_back(en);
  endtask

  task automatic step(bit v, bit clr, logic [7:0] ta, logic [7:0] tb, logic [2:0] top,
                      logic [7:0] tgot);
    entry_t en;
    @(posedge clk); #1;
    in_valid = v; clear = clr; a = ta; b = tb; op = top; dut_out = tgot;
    if (clr) begin
      while (sb.size() > 0 && int'(sb[$].due) > cyc) void'(sb.pop_back());
      mdl    = '0;
      en.due = cyc + 1;
      en.s   = '0;
      sb.push_back(en);
    end else if (v) begin
      model_issue(ta, tb, top, tgot);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 8'h00);
  endtask

  task automatic async_reset();
    entry_t en;
    @(posedge clk); #2;
    in_valid = 1'b0; clear = 1'b0; rst_n = 1'b0;
    while (sb.size() > 0 && int'(sb[$].due) >= cyc) void'(sb.pop_back());
    mdl    = '0;
    en.due = cyc;
    en.s   = '0;
    sb.push_back(en);
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  function automatic snap_t mk(logic m, logic [31:0] t, logic [31:0] e, logic [1:0] s, logic v,
                               logic [7:0] x, logic [7:0] y, logic [2:0] o, logic [7:0] g,
                               logic [7:0] xe);
    snap_t r;
    r.mm = m; r.txn = t; r.err = e; r.st = s; r.fev = v;
    r.fa = x; r.fb = y; r.fop = o; r.fgot = g; r.fexp = xe;
    return r;
  endfunction

  // Monitor: applies any scoreboard entry due this cycle, then compares every instance.
  always @(negedge clk) begin
    snap_t [2:0] got;
    if (sb.size() > 0 && int'(sb[0].due) == cyc) begin
      entry_t en;
      en  = sb.pop_front();
      cur = en.s;
    end else begin
      for (int i = 0; i < 3; i++) cur[i].mm = 1'b0;
    end
    got[0] = mk(mm0, 32'(txn0), 32'(err0), st0, fev0, fa0, fb0, fo0, fg0, fe0);
    got[1] = mk(mm1, 32'(txn1), 32'(err1), st1, fev1, fa1, fb1, fo1, fg1, fe1);
    got[2] = mk(mm2, 32'(txn2), 32'(err2), st2, fev2, fa2, fb2, fo2, fg2, fe2);
    if (mm2) u2_pulses++;
    for (int i = 0; i < 3; i++) begin
      check("mismatch", i, 64'(got[i].mm), 64'(cur[i].mm));
      check("txn_cnt", i, 64'(got[i].txn), 64'(cur[i].txn));
      check("err_cnt", i, 64'(got[i].err), 64'(cur[i].err));
      check("state", i, 64'(got[i].st), 64'(cur[i].st));
      check("first_capture", i,
            64'({got[i].fev, got[i].fa, got[i].fb, got[i].fop, got[i].fgot, got[i].fexp}),
            64'({cur[i].fev, cur[i].fa, cur[i].fb, cur[i].fop, cur[i].fgot, cur[i].fexp}));
    end
  end

  initial begin
    logic [7:0] ra, rb, rg;
    logic [2:0] ro;
    bit         rv, rbad;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle(2);

    // Back-to-back passing tuples a=i, b=i>>1, op=i%8.
    for (int i = 0; i < 256; i++) begin
      ra = 8'(i); rb = 8'(i >> 1); ro = 3'(i % 8);
      step(1'b1, 1'b0, ra, rb, ro, ref_alu(i, i >> 1, i % 8));
    end
    idle(3);
    @(negedge clk);
    check("txn_after_256", 0, 64'(txn0), 64'd256);
    check("err_after_256", 0, 64'(err0), 64'd0);

    // Wrap and shift corner cases, all passing.
    step(1'b1, 1'b0, 8'hFF, 8'h01, 3'd0, 8'h00);
    step(1'b1, 1'b0, 8'h00, 8'h01, 3'd1, 8'hFF);
    step(1'b1, 1'b0, 8'h81, 8'h00, 3'd6, 8'h02);
    step(1'b1, 1'b0, 8'h81, 8'h00, 3'd7, 8'h40);
    idle(3);
    @(negedge clk);
    check("corner_err", 0, 64'(err0), 64'd0);

    // clear with a failing tuple on in_valid: tuple must be dropped.
    step(1'b1, 1'b1, 8'h05, 8'h05, 3'd0, 8'h00);
    step(1'b1, 1'b0, 8'd3, 8'd4, 3'd0, 8'd8);
    step(1'b1, 1'b0, 8'd1, 8'd1, 3'd4, 8'd1);
    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255)); ro = 3'($urandom_range(0, 7));
      step(1'b1, 1'b0, ra, rb, ro, ref_alu(int'(ra), int'(rb), int'(ro)));
    end
    idle(3);
    @(negedge clk);
    check("two_fail_err", 0, 64'(err0), 64'd2);
    check("two_fail_state", 0, 64'(st0), 64'd2);
    check("two_fail_first", 0, 64'({fa0, fb0, fo0, fg0, fe0}),
          64'({8'd3, 8'd4, 3'd0, 8'd8, 8'd7}));
    check("stop_txn_frozen", 1, 64'(txn1), 64'd1);
    check("stop_err_frozen", 1, 64'(err1), 64'd1);

    // Saturation of the narrow-counter instance.
    step(1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 8'h00);
    idle(2);
    @(negedge clk);
    u2_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255)); ro = 3'($urandom_range(0, 7));
      rg = ref_alu(int'(ra), int'(rb), int'(ro)) ^ 8'($urandom_range(1, 255));
      step(1'b1, 1'b0, ra, rb, ro, rg);
    end
    idle(3);
    @(negedge clk);
    check("sat_err", 2, 64'(err2), 64'd15);
    check("sat_txn", 2, 64'(txn2), 64'd15);
    check("sat_pulses", 2, 64'(u2_pulses), 64'd20);
    check("unsat_err", 0, 64'(err0), 64'd20);

    // Random traffic with a clear and an async reset mid-stream.
    for (int k = 0; k < 300; k++) begin
      if (k == 200) async_reset();
      rv   = ($urandom_range(0, 3) != 0);
      rbad = ($urandom_range(0, 9) == 0);
      ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255)); ro = 3'($urandom_range(0, 7));
      rg = ref_alu(int'(ra), int'(rb), int'(ro));
      if (rbad) rg = rg ^ 8'($urandom_range(1, 255));
      step(rv || (k == 100), (k == 100) || (k == 150), ra, rb, ro, rg);
    end
    idle(4);
    @(negedge clk);
    check("scoreboard_drained", 0, 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
